// File: rtl/arbitro_memoria_pkg.sv
// Shared types and constants for the memory arbiter slice.
// The FSM encoding and the port identifiers are used by the arbiter top,
// its round-robin picker and any bench that wants to decode the debug state.
package mem_pkg;

    // Arbiter FSM states; encoding 3 is never produced and falls back to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_st_t;

    // Port identifiers, also the encoding of the owner output
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Width of the read-latency counter (holds LAT-1 for LAT up to 15)
    localparam int CNT_W = 4;

    // Value loaded into the latency counter on a grant
    function automatic logic [CNT_W-1:0] cntInit(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/arbitro_memoria_if.sv
// Bus bundle between the two requesters (fetch F and load/store D),
// the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface arbitro_memoria_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    // Fetch port
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_done;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;

    // Shared read data returned to whichever port was served
    logic [DATA_W-1:0] rdata;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Debug visibility
    logic              owner;
    logic [1:0]        state;

    modport slave (
        input  f_req, f_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output f_done, d_done, rdata,
        output mem_addr, mem_wdata, mem_we,
        output owner, state
    );

    modport master (
        output f_req, f_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  f_done, d_done, rdata,
        input  mem_addr, mem_wdata, mem_we,
        input  owner, state
    );

endinterface

// File: rtl/arbitro_memoria_rr2.sv
// Two-way round-robin pick between the fetch and load/store requesters.
// Purely combinational: the caller owns the "last winner" register.
module arbitro_rr2
    import mem_pkg::*;
(
    input  logic f_req_i,
    input  logic d_req_i,
    input  logic rr_last_i,
    output logic grant_o,
    output logic winner_o
);

    // A lone requester always wins; on a conflict the port that did not win last time goes
    always_comb begin
        grant_o  = f_req_i | d_req_i;
        winner_o = PORT_F;
        if (f_req_i && d_req_i) begin
            winner_o = ~rr_last_i;
        end else if (d_req_i) begin
            winner_o = PORT_D;
        end
    end

endmodule

// File: rtl/arbitro_memoria.sv
// Memory arbiter for the multicycle MIPS datapath.
// Shares one instruction/data memory between fetch (F) and load/store (D),
// sequencing every access through IDLE -> ACCESS -> RESP so the control unit
// only raises a request and waits for its done pulse.
// All memory-facing outputs come from registers latched at grant time.
module arbitro_memoria
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic               clock,
    input  logic               reset,
    arbitro_memoria_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = cntInit(LAT);

    arb_st_t           state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              owner_q,  owner_d;
    logic              rrLast_q, rrLast_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              we_q,     we_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;

    logic              grant;
    logic              winner;

    arbitro_rr2 u_rr2 (
        .f_req_i   (bus.f_req),
        .d_req_i   (bus.d_req),
        .rr_last_i (rrLast_q),
        .grant_o   (grant),
        .winner_o  (winner)
    );

    // State and datapath registers; reset leaves rrLast on D so F wins the first conflict
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= PORT_F;
            rrLast_q <= PORT_D;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            rrLast_q <= rrLast_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state logic: grant and latch in IDLE, count out the read latency in ACCESS, one-cycle RESP
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        rrLast_d = rrLast_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d  = winner;
                    rrLast_d = winner;
                    if (winner == PORT_D) begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        we_d    = bus.d_we;
                    end else begin
                        addr_d  = bus.f_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Writes spend exactly one cycle in ACCESS, so this gives a single registered-only write pulse
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Done pulses go only to the port that owns the current access
    assign bus.f_done = (state_q == RESP) && (owner_q == PORT_F);
    assign bus.d_done = (state_q == RESP) && (owner_q == PORT_D);

    assign bus.rdata = rdata_q;
    assign bus.owner = owner_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria.
// Two instances share the clock and reset: dut2 with LAT=2 and dut1 with LAT=1.
// Expected completions (port, rdata, cycle) are queued when a request is driven
// and compared when a done pulse appears.
module tb_arbitro_memoria;
    import mem_pkg::*;

    localparam int LAT2 = 2;
    localparam int LAT1 = 1;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cycle;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int   cycleCnt   = 0;
    int   checkCount = 0;
    int   errorCount = 0;

    exp_t sb2[$];
    exp_t sb1[$];
    logic [31:0] expRdata2 = '0;
    logic [31:0] expRdata1 = '0;

    int          weCount = 0;
    logic [31:0] weAddr  = '0;
    logic [31:0] weData  = '0;

    arbitro_memoria_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
    arbitro_memoria_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    arbitro_memoria #(.ADDR_W(32), .DATA_W(32), .LAT(LAT2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    arbitro_memoria #(.ADDR_W(32), .DATA_W(32), .LAT(LAT1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // Memory contents as a fixed function of the address
    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h8C22_0010;
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    assign bus2.mem_rdata = memFn(bus2.mem_addr);
    assign bus1.mem_rdata = memFn(bus1.mem_addr);

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cycleCnt++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Queue one expected completion on dut2 for a request sampled at edge issueEdge
    task automatic pushExp2(input logic port, input logic we, input logic [31:0] addr, input int issueEdge);
        exp_t e;
        if (!we) expRdata2 = memFn(addr);
        e.port  = port;
        e.data  = expRdata2;
        e.cycle = issueEdge + (we ? 1 : LAT2);
        sb2.push_back(e);
    endtask

    task automatic pushExp1(input logic [31:0] addr, input int issueEdge);
        exp_t e;
        expRdata1 = memFn(addr);
        e.port  = PORT_F;
        e.data  = expRdata1;
        e.cycle = issueEdge + LAT1;
        sb1.push_back(e);
    endtask

    // Drive one request on dut2 (DUT idle) and record its expected completion
    task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == PORT_D) begin
            bus2.d_req   = 1'b1;
            bus2.d_we    = we;
            bus2.d_addr  = addr;
            bus2.d_wdata = wdata;
        end else begin
            bus2.f_req  = 1'b1;
            bus2.f_addr = addr;
        end
        pushExp2(port, (port == PORT_D) ? we : 1'b0, addr, cycleCnt + 1);
    endtask

    task automatic waitDrain2(input int bound);
        int n = 0;
        while (sb2.size() != 0 && n < bound) begin
            @(negedge clock); #1;
            n++;
        end
        checkOutput("drain2", 32'(sb2.size()), 32'd0);
    endtask

    task automatic dropReqs2();
        @(posedge clock); #1;
        bus2.f_req = 1'b0;
        bus2.d_req = 1'b0;
        bus2.d_we  = 1'b0;
    endtask

    task automatic resetDuts();
        reset = 1'b0;
        bus2.f_req = 1'b0; bus2.f_addr = '0;
        bus2.d_req = 1'b0; bus2.d_we = 1'b0; bus2.d_addr = '0; bus2.d_wdata = '0;
        bus1.f_req = 1'b0; bus1.f_addr = '0;
        bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
        sb2.delete();
        sb1.delete();
        expRdata2 = '0;
        expRdata1 = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        weCount = 0;
    endtask

    task automatic checkIdle2(input string tag);
        checkOutput({tag, "_state"},  32'(bus2.state),  32'd0);
        checkOutput({tag, "_fdone"},  32'(bus2.f_done), 32'd0);
        checkOutput({tag, "_ddone"},  32'(bus2.d_done), 32'd0);
        checkOutput({tag, "_rdata"},  bus2.rdata,       32'd0);
        checkOutput({tag, "_maddr"},  bus2.mem_addr,    32'd0);
        checkOutput({tag, "_mwdata"}, bus2.mem_wdata,   32'd0);
        checkOutput({tag, "_mwe"},    32'(bus2.mem_we), 32'd0);
        checkOutput({tag, "_owner"},  32'(bus2.owner),  32'd0);
    endtask

    // Scoreboard for dut2: every done must match the head of the queue
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (bus2.mem_we) begin
            weCount++;
            weAddr = bus2.mem_addr;
            weData = bus2.mem_wdata;
        end
        if (bus2.f_done || bus2.d_done) begin
            if (sb2.size() == 0) begin
                checkOutput("unexpected_done2", 32'(bus2.d_done), 32'(bus2.d_done ^ 1'b1));
            end else begin
                e = sb2.pop_front();
                checkOutput("one_done2", 32'(bus2.f_done & bus2.d_done), 32'd0);
                checkOutput("port2",     32'(bus2.d_done), 32'(e.port));
                checkOutput("owner2",    32'(bus2.owner),  32'(e.port));
                checkOutput("cycle2",    32'(cycleCnt),    32'(e.cycle));
                checkOutput("rdata2",    bus2.rdata,       e.data);
                checkOutput("state2",    32'(bus2.state),  32'd2);
            end
        end
    end

    // Scoreboard for dut1 (fetch only)
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (bus1.f_done || bus1.d_done) begin
            if (sb1.size() == 0) begin
                checkOutput("unexpected_done1", 32'd1, 32'd0);
            end else begin
                e = sb1.pop_front();
                checkOutput("port1",  32'(bus1.d_done), 32'(e.port));
                checkOutput("cycle1", 32'(cycleCnt),    32'(e.cycle));
                checkOutput("rdata1", bus1.rdata,       e.data);
            end
        end
        checkOutput("mwe1", 32'(bus1.mem_we), 32'd0);
    end

    initial begin
        int c0;
        logic [31:0] lat1Addr [3];

        resetDuts();
        reset = 1'b0;
        @(posedge clock); #1;
        checkIdle2("inreset");
        reset = 1'b1;

        // Reset in the middle of a store: the write pulse drops at once, no done
        @(posedge clock); #1;
        bus2.d_req = 1'b1; bus2.d_we = 1'b1; bus2.d_addr = 32'h40; bus2.d_wdata = 32'h1234_5678;
        @(posedge clock); #1;
        checkOutput("store_we_on",   32'(bus2.mem_we), 32'd1);
        checkOutput("store_addr_on", bus2.mem_addr,    32'h40);
        #2 reset = 1'b0;
        #1;
        checkOutput("reset_we_drop", 32'(bus2.mem_we), 32'd0);
        checkOutput("reset_state",   32'(bus2.state),  32'd0);
        bus2.d_req = 1'b0; bus2.d_we = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        checkIdle2("after_reset");
        repeat (3) @(posedge clock);
        #1 weCount = 0;

        // Single fetch
        applyStimulus(PORT_F, 1'b0, 32'h0000_0004, 32'h0);
        waitDrain2(20);
        dropReqs2();
        checkOutput("fetch_no_we",  32'(weCount), 32'd0);
        checkOutput("fetch_rdata",  bus2.rdata,   32'h8C22_0010);

        // Single store
        @(posedge clock); #1;
        applyStimulus(PORT_D, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        waitDrain2(20);
        dropReqs2();
        checkOutput("store_we_count", 32'(weCount), 32'd1);
        checkOutput("store_addr",     weAddr,       32'h0000_0100);
        checkOutput("store_wdata",    weData,       32'hDEAD_BEEF);
        checkOutput("store_rdata",    bus2.rdata,   32'h8C22_0010);

        // Both ports held from reset: strict F, D, F, D alternation every LAT+2 cycles
        resetDuts();
        @(posedge clock); #1;
        bus2.f_req = 1'b1; bus2.f_addr = 32'h10;
        bus2.d_req = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h20;
        c0 = cycleCnt + 1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) pushExp2(PORT_F, 1'b0, 32'h10, c0 + k * (LAT2 + 2));
            else            pushExp2(PORT_D, 1'b0, 32'h20, c0 + k * (LAT2 + 2));
        end
        waitDrain2(40);
        dropReqs2();

        // Load request dropped one cycle after its grant while a fetch queues up
        @(posedge clock); #1;
        bus2.d_req = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h30;
        c0 = cycleCnt + 1;
        pushExp2(PORT_D, 1'b0, 32'h30, c0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus2.d_req = 1'b0;
        bus2.f_req = 1'b1; bus2.f_addr = 32'h8;
        pushExp2(PORT_F, 1'b0, 32'h8, c0 + LAT2 + 2);
        waitDrain2(30);
        dropReqs2();

        // LAT=1 instance: back-to-back fetches every 3 cycles with f_req held
        lat1Addr[0] = 32'h200;
        lat1Addr[1] = 32'h204;
        lat1Addr[2] = 32'h4;
        @(posedge clock); #1;
        bus1.f_req = 1'b1; bus1.f_addr = lat1Addr[0];
        c0 = cycleCnt + 1;
        for (int k = 0; k < 3; k++) pushExp1(lat1Addr[k], c0 + k * (LAT1 + 2));
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!bus1.f_done && n < 20);
            if (!bus1.f_done) checkOutput("lat1_timeout", 32'd0, 32'd1);
            if (k < 2) bus1.f_addr = lat1Addr[k + 1];
        end
        @(posedge clock); #1;
        bus1.f_req = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("drain1", 32'(sb1.size()), 32'd0);
        checkOutput("lat1_state", 32'(bus1.state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
